// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit_pkg
// Purpose  : Shared widths and FSM state encoding for the MEM-stage unit.
// Revision : 1.0 - initial release
// ============================================================================
package mem_access_unit_pkg;

  localparam int DSIZE_DEF  = 16;
  localparam int ASIZE_DEF  = 5;
  localparam int MASIZE_DEF = 8;

  // 2'd3 is unused; the FSM treats it as illegal and returns to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit_if
// Purpose  : Data-memory req/ack bus between the MEM stage and the memory.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_access_unit_if
  import mem_access_unit_pkg::*;
#(
  parameter int DSIZE  = DSIZE_DEF,
  parameter int MASIZE = MASIZE_DEF
);
  logic              mem_req;
  logic              mem_we;
  logic [MASIZE-1:0] mem_addr;
  logic [DSIZE-1:0]  mem_wdata;
  logic              mem_ack;
  logic [DSIZE-1:0]  mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit_mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_stage
// Purpose  : MEM/WB pipeline register; a bubble suppresses the write enable.
// Revision : 1.0 - initial release
// ============================================================================
module mem_wb_stage
  import mem_access_unit_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int ASIZE = ASIZE_DEF
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             bubble_i,
  input  wire logic [DSIZE-1:0] wb_data_i,
  input  wire logic [ASIZE-1:0] waddr_i,
  input  wire logic             wen_i,
  output logic      [DSIZE-1:0] wb_data_o,
  output logic      [ASIZE-1:0] waddr_o,
  output logic                  wen_o
);

  // Capture write-back fields every cycle; a bubble only kills the enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_data_o <= '0;
      waddr_o   <= '0;
      wen_o     <= 1'b0;
    end else begin
      wb_data_o <= wb_data_i;
      waddr_o   <= waddr_i;
      wen_o     <= wen_i & ~bubble_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : MEM stage: load/store over req/ack, pipeline stall generation,
//            MEM/WB register and a saturating stall-cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DSIZE  = DSIZE_DEF,
  parameter int ASIZE  = ASIZE_DEF,
  parameter int MASIZE = MASIZE_DEF
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic [DSIZE-1:0]  result_in,
  input  wire logic [DSIZE-1:0]  rdata2_in,
  input  wire logic [ASIZE-1:0]  waddr_in,
  input  wire logic              wen_in,
  input  wire logic              memwrite_in,
  input  wire logic              memread_in,
  input  wire logic              memtoreg_in,
  mem_access_unit_if.master      mem_bus,
  output logic                   stall,
  output logic      [DSIZE-1:0]  wb_data_out,
  output logic      [ASIZE-1:0]  waddr_out,
  output logic                   wen_out,
  output logic      [15:0]       stall_cnt
);

  localparam logic [15:0] C_CNT_MAX = 16'hFFFF;

  state_e              state_q;
  logic                mem_req_q;
  logic                mem_we_q;
  logic [MASIZE-1:0]   mem_addr_q;
  logic [DSIZE-1:0]    mem_wdata_q;
  logic [DSIZE-1:0]    load_q;
  logic [15:0]         stall_cnt_q;
  logic                w_mem_op;
  logic [DSIZE-1:0]    w_wb_data_d;

  assign w_mem_op = memread_in | memwrite_in;

  // Freeze upstream while a new op is being launched or an access is pending.
  // Gated by reset so the pipeline is never frozen while held in reset.
  assign stall = rst & (((state_q == ST_IDLE) & w_mem_op) | (state_q == ST_WAIT));

  // In DONE the completed instruction is still on the inputs, so select its
  // load data; everywhere else the ALU result passes straight through.
  assign w_wb_data_d = ((state_q == ST_DONE) && memtoreg_in) ? load_q : result_in;

  // Access FSM with registered memory-bus outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      load_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_mem_op) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= memwrite_in;
            mem_addr_q  <= result_in[MASIZE-1:0];
            mem_wdata_q <= rdata2_in;
            state_q     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_bus.mem_ack) begin
            // A store (including read+write) never consumes read data.
            if (!mem_we_q) begin
              load_q <= mem_bus.mem_rdata;
            end
            mem_req_q <= 1'b0;
            state_q   <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          mem_req_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  // Count stalled cycles, sticking at the maximum value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != C_CNT_MAX)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign mem_bus.mem_req   = mem_req_q;
  assign mem_bus.mem_we    = mem_we_q;
  assign mem_bus.mem_addr  = mem_addr_q;
  assign mem_bus.mem_wdata = mem_wdata_q;
  assign stall_cnt         = stall_cnt_q;

  mem_wb_stage #(
    .DSIZE (DSIZE),
    .ASIZE (ASIZE)
  ) u_mem_wb_stage (
    .clk       (clk),
    .rst       (rst),
    .bubble_i  (stall),
    .wb_data_i (w_wb_data_d),
    .waddr_i   (waddr_in),
    .wen_i     (wen_in),
    .wb_data_o (wb_data_out),
    .waddr_o   (waddr_out),
    .wen_o     (wen_out)
  );

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Scoreboard bench for mem_access_unit with a delayed-ack memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  typedef struct packed {
    logic [15:0] d;
    logic [4:0]  a;
  } wb_t;

  typedef struct packed {
    logic        we;
    logic [7:0]  a;
    logic [15:0] wd;
  } req_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] result_in;
  logic [15:0] rdata2_in;
  logic [4:0]  waddr_in;
  logic        wen_in;
  logic        memwrite_in;
  logic        memread_in;
  logic        memtoreg_in;
  logic        stall;
  logic [15:0] wb_data_out;
  logic [4:0]  waddr_out;
  logic        wen_out;
  logic [15:0] stall_cnt;

  logic        ack_r;
  logic        spur_ack;
  logic [15:0] rdata_r;
  int          ack_delay;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_stall_total = 0;

  wb_t  wbq[$];
  req_t reqq[$];

  mem_access_unit_if bus ();

  assign bus.mem_ack   = ack_r | spur_ack;
  assign bus.mem_rdata = rdata_r;

  mem_access_unit dut (
    .clk         (clk),
    .rst         (rst),
    .result_in   (result_in),
    .rdata2_in   (rdata2_in),
    .waddr_in    (waddr_in),
    .wen_in      (wen_in),
    .memwrite_in (memwrite_in),
    .memread_in  (memread_in),
    .memtoreg_in (memtoreg_in),
    .mem_bus     (bus),
    .stall       (stall),
    .wb_data_out (wb_data_out),
    .waddr_out   (waddr_out),
    .wen_out     (wen_out),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Memory contents seen by loads.
  function automatic logic [15:0] mem_model(input logic [7:0] a);
    if (a == 8'h42) return 16'hBEEF;
    return {~a, a};
  endfunction

  // Memory responder: ack after ack_delay cycles of mem_req high.
  initial begin
    int cnt;
    ack_r = 1'b0;
    rdata_r = '0;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (bus.mem_req) begin
        if (cnt == ack_delay) begin
          ack_r   = 1'b1;
          rdata_r = mem_model(bus.mem_addr);
        end else begin
          ack_r = 1'b0;
        end
        cnt++;
      end else begin
        cnt     = 0;
        ack_r   = 1'b0;
        rdata_r = spur_ack ? 16'hDEAD : 16'h0000;
      end
    end
  end

  // Write-back monitor.
  initial begin
    wb_t got, exp;
    forever begin
      @(negedge clk);
      if (rst && wen_out) begin
        got.d = wb_data_out;
        got.a = waddr_out;
        if (wbq.size() == 0) begin
          chk("wb_unexpected", {11'd0, got}, 32'h0);
        end else begin
          exp = wbq.pop_front();
          chk("wb_data_addr", {11'd0, got}, {11'd0, exp});
        end
      end
    end
  end

  // Memory request monitor: fields at launch, stability, and request gap.
  initial begin
    req_t cur, hold, exp;
    logic prev_req;
    logic have_req;
    int   low_cnt;
    prev_req = 1'b0;
    have_req = 1'b0;
    low_cnt  = 0;
    hold     = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_req) begin
        cur.we = bus.mem_we;
        cur.a  = bus.mem_addr;
        cur.wd = bus.mem_wdata;
        if (!prev_req) begin
          if (have_req) chk("req_gap_ge2", {31'd0, low_cnt >= 2}, 32'd1);
          if (reqq.size() == 0) begin
            chk("req_unexpected", {7'd0, cur}, 32'h0);
          end else begin
            exp = reqq.pop_front();
            chk("req_fields", {7'd0, cur}, {7'd0, exp});
          end
          hold     = cur;
          have_req = 1'b1;
        end else begin
          chk("req_hold", {7'd0, cur}, {7'd0, hold});
        end
        low_cnt = 0;
      end else begin
        low_cnt++;
      end
      prev_req = bus.mem_req;
    end
  end

  task automatic set_nop();
    result_in   = '0;
    rdata2_in   = '0;
    waddr_in    = '0;
    wen_in      = 1'b0;
    memwrite_in = 1'b0;
    memread_in  = 1'b0;
    memtoreg_in = 1'b0;
  endtask

  // Present one instruction (called just after a negedge) and hold it until
  // the pipeline consumes it; checks stall length and the running stall count.
  task automatic issue(input logic [15:0] res, input logic [15:0] rd2,
                       input logic [4:0] wa, input logic we, input logic mr,
                       input logic mw, input logic m2r, input int dly,
                       input logic [15:0] exp_wb, input int exp_st);
    wb_t  e;
    req_t r;
    int   st;
    result_in   = res;
    rdata2_in   = rd2;
    waddr_in    = wa;
    wen_in      = we;
    memread_in  = mr;
    memwrite_in = mw;
    memtoreg_in = m2r;
    ack_delay   = dly;
    if (we) begin
      e.d = exp_wb;
      e.a = wa;
      wbq.push_back(e);
    end
    if (mr | mw) begin
      r.we = mw;
      r.a  = res[7:0];
      r.wd = rd2;
      reqq.push_back(r);
    end
    exp_stall_total += exp_st;
    st = 0;
    #1;
    while (stall && st < 200) begin
      st++;
      @(negedge clk);
      #1;
    end
    chk("stall_cycles", st, exp_st);
    @(negedge clk);
    set_nop();
    chk("stall_cnt", {16'd0, stall_cnt}, exp_stall_total);
  endtask

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    spur_ack = 1'b0;
    ack_delay = 0;
    set_nop();
    @(negedge clk);
    #1;
    chk("rst_mem_req",   {31'd0, bus.mem_req},   32'd0);
    chk("rst_mem_we",    {31'd0, bus.mem_we},    32'd0);
    chk("rst_mem_addr",  {24'd0, bus.mem_addr},  32'd0);
    chk("rst_mem_wdata", {16'd0, bus.mem_wdata}, 32'd0);
    chk("rst_wb_data",   {16'd0, wb_data_out},   32'd0);
    chk("rst_waddr",     {27'd0, waddr_out},     32'd0);
    chk("rst_wen",       {31'd0, wen_out},       32'd0);
    chk("rst_stall_cnt", {16'd0, stall_cnt},     32'd0);
    chk("rst_stall",     {31'd0, stall},         32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // ALU op: no stall, one-cycle write-back.
    issue(16'h1234, 16'h0000, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 0, 16'h1234, 0);
    // Load, zero-wait ack.
    issue(16'h0042, 16'h0000, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 0, 16'hBEEF, 2);
    // Store, ack after 3 extra cycles; no write-back.
    issue(16'h0010, 16'hA5A5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3, 16'h0000, 5);
    // Back-to-back loads.
    issue(16'h0001, 16'h0000, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1, 0, 16'hFE01, 2);
    issue(16'h0002, 16'h0000, 5'd11, 1'b1, 1'b1, 1'b0, 1'b1, 0, 16'hFD02, 2);
    // Address bits above the memory width are discarded.
    issue(16'h1F80, 16'h0000, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1, 16'h7F80, 3);
    // Read+write together acts as a store; write-back takes result_in.
    issue(16'h0033, 16'h5555, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 0, 16'h0033, 2);

    // Reset while waiting for an ack that never comes.
    begin
      req_t r;
      ack_delay   = 1000;
      result_in   = 16'h0055;
      waddr_in    = 5'd12;
      wen_in      = 1'b1;
      memread_in  = 1'b1;
      memtoreg_in = 1'b1;
      r.we = 1'b0;
      r.a  = 8'h55;
      r.wd = 16'h0000;
      reqq.push_back(r);
      repeat (3) @(negedge clk);
      #1;
      chk("wait_stall",   {31'd0, stall},       32'd1);
      chk("wait_mem_req", {31'd0, bus.mem_req}, 32'd1);
      #1;
      rst = 1'b0;
      #1;
      chk("arst_mem_req",   {31'd0, bus.mem_req}, 32'd0);
      chk("arst_stall",     {31'd0, stall},       32'd0);
      chk("arst_wen",       {31'd0, wen_out},     32'd0);
      chk("arst_stall_cnt", {16'd0, stall_cnt},   32'd0);
      set_nop();
      @(negedge clk);
      rst = 1'b1;
      exp_stall_total = 0;
      ack_delay = 0;
      spur_ack = 1'b1;
      repeat (3) begin
        @(negedge clk);
        #1;
        chk("spur_mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("spur_stall",   {31'd0, stall},       32'd0);
      end
      spur_ack = 1'b0;
      @(negedge clk);
    end

    // Normal operation resumes from IDLE after the abandoned access.
    issue(16'h0F0F, 16'h0000, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0, 0, 16'h0F0F, 0);
    issue(16'h0042, 16'h0000, 5'd14, 1'b1, 1'b1, 1'b0, 1'b1, 1, 16'hBEEF, 3);

    repeat (4) @(negedge clk);
    chk("wbq_drained",  wbq.size(),  32'd0);
    chk("reqq_drained", reqq.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage consumer of the EXE/MEM pipeline register outputs: performs data-memory loads and stores over a req/ack handshake and stalls the pipeline while an access is pending.
- Contains the MEM/WB pipeline register and drives the write-back fields: data, destination register and write enable.
- Sits between the EXE/MEM register and the WB stage; `stall` freezes PC, IF/ID, ID/EXE and EXE/MEM.

Parameters:
- DSIZE, 16, datapath width (result, store data, load data).
- ASIZE, 5, register-file address width.
- MASIZE, 8, data-memory word-address width; taken from result_in[MASIZE-1:0].

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- result_in  in  DSIZE  ALU result; memory address for loads and stores.
- rdata2_in  in  DSIZE  store data.
- waddr_in  in  ASIZE  destination register.
- wen_in  in  1  register write enable.
- memwrite_in  in  1  store.
- memread_in  in  1  load.
- memtoreg_in  in  1  1 = write-back load data, 0 = write-back result_in.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  1 = write, registered.
- mem_addr  out  MASIZE  registered.
- mem_wdata  out  DSIZE  registered.
- mem_ack  in  1  access complete; load data is valid on mem_rdata in the same cycle.
- mem_rdata  in  DSIZE  load data.
- stall  out  1  combinational pipeline freeze.
- wb_data_out  out  DSIZE  MEM/WB write-back data.
- waddr_out  out  ASIZE  MEM/WB destination register.
- wen_out  out  1  MEM/WB write enable.
- stall_cnt  out  16  saturating count of stalled cycles.

Behaviour:
- Reset (rst=0, async): state=IDLE; all registered outputs 0, including mem_req, mem_we, mem_addr, mem_wdata, wb_data_out, waddr_out, wen_out and stall_cnt. stall=0.
- Reset mid-access: mem_req drops immediately and the in-flight access is abandoned.
- Memory op: mem_op = memread_in | memwrite_in. If both are 1, treat it as a store; mem_rdata is ignored.
- FSM states: IDLE, WAIT, DONE.
- IDLE, mem_op=0:
  - stall=0.
  - MEM/WB loads result_in, waddr_in, wen_in (1-cycle latency).
- IDLE, mem_op=1:
  - stall=1; MEM/WB loads a bubble (wen_out<=0).
  - Register mem_req<=1, mem_we<=memwrite_in, mem_addr<=result_in[MASIZE-1:0], mem_wdata<=rdata2_in.
  - Go to WAIT.
- WAIT:
  - stall=1; MEM/WB loads bubbles.
  - mem_req, mem_we, mem_addr and mem_wdata are held stable until mem_ack.
  - On mem_ack: capture mem_rdata into an internal load register, mem_req<=0, go to DONE.
  - With no ack, stay in WAIT indefinitely (no timeout).
- DONE:
  - stall=0.
  - MEM/WB loads wb_data = memtoreg_in ? load register : result_in, plus waddr_in and wen_in.
  - The EXE/MEM inputs still hold the completed instruction, so mem_op is ignored this cycle.
  - Go to IDLE unconditionally.
- Back-to-back memory ops: the next op is recognised in the IDLE cycle after DONE. The minimum gap between requests is 2 cycles (req drops in DONE, rises again after IDLE).
- mem_ack outside WAIT is ignored.
- Latency, load with ack in the first cycle mem_req is high:
  - stall high for 2 cycles (IDLE, WAIT).
  - DONE on the 3rd cycle.
  - wen_out/wb_data_out visible on the 4th cycle.
- stall_cnt: increments on every clock edge where stall=1; saturates at 16'hFFFF; cleared only by reset.
- Widths: no arithmetic apart from stall_cnt. Address bits of result_in above MASIZE are discarded.

Decomposition:
- Shared package/define file: DSIZE, ASIZE, MASIZE defaults and the state encoding (IDLE=2'd0, WAIT=2'd1, DONE=2'd2). Encoding 2'd3 is illegal and recovers to IDLE.
- One sub-module, mem_wb_stage: MEM/WB register with async active-low reset and a bubble input forcing wen_out<=0. The FSM, handshake and stall_cnt stay in mem_access_unit.

Test Plan:
- ALU op: result_in=16'h1234, waddr_in=5'd3, wen_in=1, memread/memwrite=0 -> next cycle wb_data_out=16'h1234, waddr_out=3, wen_out=1; stall never high; mem_req stays 0.
- Load, zero-wait: result_in=16'h0042, memread_in=1, memtoreg_in=1, waddr_in=5'd7; mem_ack=1 with mem_rdata=16'hBEEF in the first req cycle -> mem_addr=8'h42, mem_we=0; stall high for 2 cycles; then wb_data_out=16'hBEEF, waddr_out=7, wen_out=1; stall_cnt=2.
- Store, 3-cycle ack delay: result_in=16'h0010, rdata2_in=16'hA5A5, memwrite_in=1, wen_in=0 -> mem_req high 4 cycles with mem_we=1, mem_addr=8'h10, mem_wdata=16'hA5A5 held stable; stall high 5 cycles; wen_out=0 throughout.
- Back-to-back loads to 8'h01 then 8'h02 -> two distinct requests; mem_req low for at least 1 cycle between them; both write-backs occur in order.
- Reset asserted in WAIT -> mem_req, stall, wen_out and stall_cnt go to 0 immediately (asynchronously); after release, a spurious mem_ack=1 is ignored and state stays IDLE.
- memread_in=memwrite_in=1 -> mem_we=1; wb_data_out takes result_in regardless of mem_rdata when memtoreg_in=0.
